// File: rtl/rd_req_arbiter.sv
// Round-robin arbiter sharing one AXI read path between two refill ports.
// One outstanding 4-beat INCR burst; watchdog aborts a stalled data phase.
module rd_req_arbiter #(
  parameter logic [3:0] ID0        = 4'h1,
  parameter logic [3:0] ID1        = 4'h2,
  parameter int         TMO_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [31:0]  req0_addr,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic [127:0] rsp0_data,
  input  logic         req1_valid,
  input  logic [31:0]  req1_addr,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic [127:0] rsp1_data,
  output logic         arvalid,
  input  logic         arready,
  output logic [31:0]  araddr,
  output logic [3:0]   arid,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         next_rrq,
  output logic [3:0]   next_rid,
  input  logic         rdat_m_valid,
  input  logic [127:0] rdat_m_data,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  localparam logic [9:0] TMO_M1 = 10'(TMO_CYCLES - 1);

  state_t         r_state;
  state_t         w_nstate;
  logic           r_rr_ptr;
  logic           r_winner;
  logic           r_first;
  logic [9:0]     r_wdog;
  logic           r_tmo;
  logic [31:0]    r_araddr;
  logic [3:0]     r_arid;
  logic           r_rsp0_v;
  logic           r_rsp1_v;
  logic [127:0]   r_rsp0_d;
  logic [127:0]   r_rsp1_d;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_tmo_hit;
  logic [31:0]    w_sel_addr;
  logic           w_unused;

  // Low address nibble is replaced by the line alignment.
  assign w_unused = ^{req0_addr[3:0], req1_addr[3:0]};

  assign w_tmo_hit  = (r_state == S_DATA) & ~rdat_m_valid
                    & (r_wdog == TMO_M1);
  assign w_sel_addr = w_gnt1 ? req1_addr : req0_addr;

  // Grant selection and next-state decode.
  always_comb begin
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE: begin
        w_gnt0 = req0_valid & (~req1_valid | ~r_rr_ptr);
        w_gnt1 = req1_valid & (~req0_valid | r_rr_ptr);
        if (w_gnt0 | w_gnt1)
          w_nstate = S_ADDR;
      end
      S_ADDR: begin
        if (arready)
          w_nstate = S_DATA;
      end
      S_DATA: begin
        if (rdat_m_valid | w_tmo_hit)
          w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_nstate;
  end

  // Request capture, watchdog and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
      r_winner <= 1'b0;
      r_first  <= 1'b0;
      r_wdog   <= '0;
      r_tmo    <= 1'b0;
      r_araddr <= '0;
      r_arid   <= '0;
      r_rsp0_v <= 1'b0;
      r_rsp1_v <= 1'b0;
      r_rsp0_d <= '0;
      r_rsp1_d <= '0;
    end else begin
      r_rsp0_v <= 1'b0;
      r_rsp1_v <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_araddr <= {w_sel_addr[31:4], 4'h0};
            r_arid   <= w_gnt1 ? ID1 : ID0;
            r_winner <= w_gnt1;
            r_rr_ptr <= ~w_gnt1;
            r_first  <= 1'b1;
            r_wdog   <= '0;
          end
        end
        S_ADDR: begin
          r_first <= 1'b0;
          r_wdog  <= '0;
        end
        S_DATA: begin
          if (rdat_m_valid) begin
            if (r_winner) begin
              r_rsp1_v <= 1'b1;
              r_rsp1_d <= rdat_m_data;
            end else begin
              r_rsp0_v <= 1'b1;
              r_rsp0_d <= rdat_m_data;
            end
          end else if (w_tmo_hit) begin
            r_tmo <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign rsp0_valid  = r_rsp0_v;
  assign rsp1_valid  = r_rsp1_v;
  assign rsp0_data   = r_rsp0_d;
  assign rsp1_data   = r_rsp1_d;
  assign arvalid     = (r_state == S_ADDR);
  assign araddr      = r_araddr;
  assign arid        = r_arid;
  assign arlen       = 8'd3;
  assign arsize      = 3'b010;
  assign arburst     = 2'b01;
  assign next_rrq    = (r_state == S_ADDR) & r_first;
  assign next_rid    = r_arid;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Randomised and directed bench for rd_req_arbiter.
// A transaction-level reference model predicts every output each cycle.
module tb_rd_req_arbiter;

  localparam int TMO = 1023;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [31:0]  req0_addr, req1_addr;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [127:0] rsp0_data, rsp1_data;
  logic         arvalid, arready;
  logic [31:0]  araddr;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         next_rrq;
  logic [3:0]   next_rid;
  logic         rdat_m_valid;
  logic [127:0] rdat_m_data;
  logic         busy, timeout_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rd_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_data(rsp1_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .next_rrq(next_rrq),
    .next_rid(next_rid), .rdat_m_valid(rdat_m_valid),
    .rdat_m_data(rdat_m_data), .busy(busy),
    .timeout_err(timeout_err)
  );

  // Reference model: one pending transaction record plus port results.
  bit           m_txn;
  bit           m_ar_pend;
  bit           m_ar_fresh;
  int           m_owner;
  int           m_pref;
  int           m_dcyc;
  logic [31:0]  m_addr;
  logic [3:0]   m_id;
  bit           m_tmo;
  bit           m_rv [2];
  logic [127:0] m_rd [2];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_txn = 0; m_ar_pend = 0; m_ar_fresh = 0;
    m_owner = 0; m_pref = 0; m_dcyc = 0;
    m_addr = '0; m_id = '0; m_tmo = 0;
    for (int p = 0; p < 2; p++) begin
      m_rv[p] = 0;
      m_rd[p] = '0;
    end
  endtask

  function automatic int pick();
    if (m_txn) return -1;
    if (req0_valid && req1_valid) return m_pref;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_advance();
    int w;
    w = pick();
    m_rv[0] = 0;
    m_rv[1] = 0;
    if (rst) begin
      model_reset();
    end else if (!m_txn) begin
      if (w >= 0) begin
        m_txn = 1; m_ar_pend = 1; m_ar_fresh = 1;
        m_owner = w;
        m_pref = 1 - w;
        m_addr = (w == 1 ? req1_addr : req0_addr) & 32'hFFFF_FFF0;
        m_id = (w == 1) ? 4'h2 : 4'h1;
      end
    end else if (m_ar_pend) begin
      m_ar_fresh = 0;
      if (arready) begin
        m_ar_pend = 0;
        m_dcyc = 0;
      end
    end else begin
      m_dcyc++;
      if (rdat_m_valid) begin
        m_rv[m_owner] = 1;
        m_rd[m_owner] = rdat_m_data;
        m_txn = 0;
      end else if (m_dcyc >= TMO) begin
        m_tmo = 1;
        m_txn = 0;
      end
    end
  endtask

  // Compare all outputs with inputs already applied, then advance one cycle.
  task automatic step();
    int w;
    #1;
    w = pick();
    chk("req0_ready", req0_ready, w == 0);
    chk("req1_ready", req1_ready, w == 1);
    chk("arvalid", arvalid, m_txn && m_ar_pend);
    chk("next_rrq", next_rrq, m_txn && m_ar_pend && m_ar_fresh);
    chk("araddr", araddr, m_addr);
    chk("arid", arid, m_id);
    chk("next_rid", next_rid, m_id);
    chk("busy", busy, m_txn);
    chk("timeout_err", timeout_err, m_tmo);
    chk("rsp0_valid", rsp0_valid, m_rv[0]);
    chk("rsp1_valid", rsp1_valid, m_rv[1]);
    chk("rsp0_data", rsp0_data, m_rd[0]);
    chk("rsp1_data", rsp1_data, m_rd[1]);
    chk("ar_const", {arlen, arsize, arburst}, {8'd3, 3'b010, 2'b01});
    model_advance();
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; req0_valid = 0; req1_valid = 0;
    req0_addr = '0; req1_addr = '0; arready = 0;
    rdat_m_valid = 0; rdat_m_data = '0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    quiet();
    rst = 1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;

    // Single port0 request, data returned in cycle 5.
    req0_valid = 1; req0_addr = 32'h0000_1234;
    step();
    req0_valid = 0; arready = 1;
    step();
    arready = 0;
    repeat (3) step();
    rdat_m_valid = 1; rdat_m_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    step();
    rdat_m_valid = 0;
    step();
    step();

    // Both ports held: expect alternating grants.
    req0_valid = 1; req1_valid = 1;
    req0_addr = 32'h1000_0008; req1_addr = 32'h2000_00FC;
    arready = 1;
    for (int t = 0; t < 3; t++) begin
      step(); step();
      rdat_m_valid = 1; rdat_m_data = rnd128();
      step();
      rdat_m_valid = 0;
    end
    quiet();
    step(); step();

    // AR stall with a stray data pulse during ADDR.
    req1_valid = 1; req1_addr = 32'hABCD_EF17;
    step();
    req1_valid = 0;
    for (int t = 0; t < 5; t++) begin
      rdat_m_valid = (t == 2); rdat_m_data = rnd128();
      step();
    end
    rdat_m_valid = 0; arready = 1;
    step();
    arready = 0;
    step();
    rdat_m_valid = 1; rdat_m_data = rnd128();
    step();
    quiet();
    step();

    // Watchdog expiry, then a normal transaction.
    req0_valid = 1; req0_addr = 32'h0000_4440;
    step();
    req0_valid = 0; arready = 1;
    step();
    arready = 0;
    repeat (TMO + 3) step();
    req0_valid = 1; req0_addr = 32'h0000_5550;
    step();
    req0_valid = 0; arready = 1;
    step();
    arready = 0; rdat_m_valid = 1; rdat_m_data = rnd128();
    step();
    quiet();
    step();

    // Reset during the data phase, late data ignored.
    req1_valid = 1; req1_addr = 32'h7777_0000;
    step();
    req1_valid = 0; arready = 1;
    step();
    arready = 0;
    step();
    rst = 1;
    step();
    rst = 0; rdat_m_valid = 1; rdat_m_data = rnd128();
    step();
    quiet();
    step();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      req0_valid   = ($urandom_range(0, 2) != 0);
      req1_valid   = ($urandom_range(0, 2) != 0);
      req0_addr    = $urandom;
      req1_addr    = $urandom;
      arready      = $urandom_range(0, 1);
      rdat_m_valid = ($urandom_range(0, 5) == 0);
      rdat_m_data  = rnd128();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
